// File: rtl/jtframe_dump_pkg.sv
// Frame-based dump scheduler: shared types and default widths.
// Imported by the scheduler top, its frame counter and its interface.
package jtframe_dump_pkg;

  localparam int DUMP_FW = 32;
  localparam int DUMP_LW = 16;
  localparam int DUMP_NW = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DL,
    ST_WAIT_START,
    ST_CAPTURE,
    ST_HOLD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/jtframe_dump_sched_if.sv
// Control/status bundle between the game side and the dump scheduler.
// master drives arm/config/video, slave is the scheduler.
interface jtframe_dump_sched_if
  import jtframe_dump_pkg::*;
#(
  parameter int FW = DUMP_FW,
  parameter int LW = DUMP_LW,
  parameter int NW = DUMP_NW
);
  logic          vs;
  logic          downloading;
  logic          arm;
  logic          abort;
  logic          periodic;
  logic [FW-1:0] start_frame;
  logic [LW-1:0] win_len;
  logic [LW-1:0] period;
  logic [FW-1:0] frame_cnt;
  logic          dump_en;
  logic          dump_start;
  logic          dump_stop;
  logic          late;
  logic [NW-1:0] win_done;
  logic          busy;

  modport master (
    output vs, downloading, arm, abort,
    output periodic, start_frame, win_len, period,
    input  frame_cnt, dump_en, dump_start, dump_stop,
    input  late, win_done, busy
  );

  modport slave (
    input  vs, downloading, arm, abort,
    input  periodic, start_frame, win_len, period,
    output frame_cnt, dump_en, dump_start, dump_stop,
    output late, win_done, busy
  );
endinterface

// File: rtl/jtframe_dump_fcnt.sv
// Frame counter: vs / downloading edge strobes and frame number.
// End of download restarts numbering at 0, overriding a same-cycle vs fall.
module jtframe_dump_fcnt
  import jtframe_dump_pkg::*;
#(
  parameter int FW = DUMP_FW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs_i,
  input  logic          dl_i,
  output logic          vs_fall_o,
  output logic          dl_fall_o,
  output logic          dl_rise_o,
  output logic [FW-1:0] frame_cnt_o
);
  logic          vs_l_q;
  logic          dl_l_q;
  logic [FW-1:0] cnt_q;
  logic [FW-1:0] cnt_d;

  assign vs_fall_o = vs_l_q & ~vs_i;
  assign dl_fall_o = dl_l_q & ~dl_i;
  assign dl_rise_o = ~dl_l_q & dl_i;
  assign frame_cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (dl_fall_o)
      cnt_d = '0;
    else if (vs_fall_o)
      cnt_d = cnt_q + FW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_l_q <= 1'b1;
      dl_l_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vs_l_q <= vs_i;
      dl_l_q <= dl_i;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/jtframe_dump_sched.sv
// Dump window scheduler: opens capture windows on frame boundaries,
// single-shot or periodic, suspended while a ROM download runs.
module jtframe_dump_sched
  import jtframe_dump_pkg::*;
#(
  parameter int FW = DUMP_FW,
  parameter int LW = DUMP_LW,
  parameter int NW = DUMP_NW
) (
  input logic clk,
  input logic rst_n,
  jtframe_dump_sched_if.slave bus
);
  logic          vs_fall;
  logic          dl_fall;
  logic          dl_rise;
  logic [FW-1:0] frame_cnt;

  state_t        state_q;
  logic          periodic_q;
  logic [FW-1:0] start_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] per_q;
  logic [LW-1:0] remain_q;
  logic [LW-1:0] gap_q;
  logic          en_q;
  logic          start_p_q;
  logic          stop_p_q;
  logic          late_q;
  logic [NW-1:0] done_q;

  jtframe_dump_fcnt #(.FW(FW)) u_fcnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .vs_i        (bus.vs),
    .dl_i        (bus.downloading),
    .vs_fall_o   (vs_fall),
    .dl_fall_o   (dl_fall),
    .dl_rise_o   (dl_rise),
    .frame_cnt_o (frame_cnt)
  );

  assign bus.frame_cnt  = frame_cnt;
  assign bus.dump_en    = en_q;
  assign bus.dump_start = start_p_q;
  assign bus.dump_stop  = stop_p_q;
  assign bus.late       = late_q;
  assign bus.win_done   = done_q;
  assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      periodic_q <= 1'b0;
      start_q    <= '0;
      len_q      <= '0;
      per_q      <= '0;
      remain_q   <= '0;
      gap_q      <= '0;
      en_q       <= 1'b0;
      start_p_q  <= 1'b0;
      stop_p_q   <= 1'b0;
      late_q     <= 1'b0;
      done_q     <= '0;
    end else begin
      start_p_q <= 1'b0;
      stop_p_q  <= 1'b0;
      if (bus.abort) begin
        state_q  <= ST_IDLE;
        en_q     <= 1'b0;
        stop_p_q <= en_q;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_DONE: begin
            if (bus.arm) begin
              periodic_q <= bus.periodic;
              start_q    <= bus.start_frame;
              len_q      <= bus.win_len;
              per_q      <= bus.period;
              late_q     <= frame_cnt > bus.start_frame;
              state_q    <= bus.downloading ? ST_WAIT_DL
                                            : ST_WAIT_START;
            end
          end
          ST_WAIT_DL: begin
            // counter restarts at 0, so nothing can be late now
            if (dl_fall) begin
              state_q <= ST_WAIT_START;
              late_q  <= 1'b0;
            end
          end
          ST_WAIT_START: begin
            if (dl_rise) begin
              state_q <= ST_WAIT_DL;
            end else if (vs_fall &&
                         (frame_cnt == start_q || late_q)) begin
              state_q   <= ST_CAPTURE;
              en_q      <= 1'b1;
              start_p_q <= 1'b1;
              remain_q  <= len_q;
            end
          end
          ST_CAPTURE: begin
            if (dl_rise) begin
              state_q  <= ST_WAIT_DL;
              en_q     <= 1'b0;
              stop_p_q <= 1'b1;
            end else if (vs_fall) begin
              if (remain_q == LW'(1)) begin
                stop_p_q <= 1'b1;
                if (~&done_q)
                  done_q <= done_q + NW'(1);
                if (periodic_q && per_q != '0) begin
                  state_q <= ST_HOLD;
                  gap_q   <= per_q;
                  en_q    <= 1'b0;
                end else if (periodic_q) begin
                  start_p_q <= 1'b1;
                  remain_q  <= len_q;
                end else begin
                  state_q <= ST_DONE;
                  en_q    <= 1'b0;
                end
              end else if (len_q != '0) begin
                remain_q <= remain_q - LW'(1);
              end
            end
          end
          ST_HOLD: begin
            if (dl_rise) begin
              state_q <= ST_WAIT_DL;
            end else if (vs_fall) begin
              if (gap_q == LW'(1)) begin
                state_q   <= ST_CAPTURE;
                en_q      <= 1'b1;
                start_p_q <= 1'b1;
                remain_q  <= len_q;
              end else begin
                gap_q <= gap_q - LW'(1);
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jtframe_dump_sched.sv
// Directed bench for the dump scheduler.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_jtframe_dump_sched;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   n_start;
  int   n_stop;
  int   s_start;
  int   s_stop;

  jtframe_dump_sched_if bus ();

  jtframe_dump_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.dump_start) n_start <= n_start + 1;
    if (bus.dump_stop)  n_stop  <= n_stop + 1;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic vfall;
    bus.vs = 1'b0;
    step();
  endtask

  task automatic vrise;
    bus.vs = 1'b1;
    step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vfall();
      vrise();
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic do_arm(input logic per, input logic [31:0] sf,
                        input logic [15:0] wl, input logic [15:0] pd);
    bus.periodic    = per;
    bus.start_frame = sf;
    bus.win_len     = wl;
    bus.period      = pd;
    bus.arm         = 1'b1;
    step();
    bus.arm         = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_start = 0; n_stop = 0;
    rst_n = 1'b0;
    bus.vs = 1'b1; bus.downloading = 1'b0;
    bus.arm = 1'b0; bus.abort = 1'b0; bus.periodic = 1'b0;
    bus.start_frame = '0; bus.win_len = '0; bus.period = '0;

    // 1: reset state, single window start=3 len=2
    do_reset();
    check("rst_cnt", bus.frame_cnt, 0);
    check("rst_en", bus.dump_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.win_done, 0);
    check("rst_late", bus.late, 0);
    do_arm(1'b0, 3, 2, 0);
    check("t1_busy", bus.busy, 1);
    check("t1_late", bus.late, 0);
    frames(3);
    check("t1_cnt3", bus.frame_cnt, 3);
    check("t1_en_pre", bus.dump_en, 0);
    vfall();
    check("t1_start", bus.dump_start, 1);
    check("t1_en", bus.dump_en, 1);
    check("t1_cnt4", bus.frame_cnt, 4);
    vrise();
    check("t1_start_1cy", bus.dump_start, 0);
    vfall();
    check("t1_en2", bus.dump_en, 1);
    check("t1_nostop", bus.dump_stop, 0);
    vrise();
    vfall();
    check("t1_stop", bus.dump_stop, 1);
    check("t1_en_off", bus.dump_en, 0);
    check("t1_wdone", bus.win_done, 1);
    check("t1_idle", bus.busy, 0);
    vrise();

    // 2: arm during download, window after download ends
    bus.downloading = 1'b1;
    step();
    do_arm(1'b0, 0, 1, 0);
    check("t2_busy", bus.busy, 1);
    frames(2);
    check("t2_en_dl", bus.dump_en, 0);
    bus.downloading = 1'b0;
    step();
    check("t2_cnt0", bus.frame_cnt, 0);
    check("t2_late", bus.late, 0);
    vfall();
    check("t2_start", bus.dump_start, 1);
    check("t2_en", bus.dump_en, 1);
    vrise();
    vfall();
    check("t2_stop", bus.dump_stop, 1);
    check("t2_wdone", bus.win_done, 2);
    check("t2_idle", bus.busy, 0);
    vrise();

    // 3: periodic len=1 period=2 start=1
    do_reset();
    do_arm(1'b1, 1, 1, 2);
    for (int c = 0; c < 9; c++) begin
      vfall();
      check("t3_en", bus.dump_en, (c % 3 == 1));
      check("t3_start", bus.dump_start, (c % 3 == 1));
      check("t3_stop", bus.dump_stop, (c % 3 == 2));
      vrise();
    end
    check("t3_wdone", bus.win_done, 3);
    check("t3_busy", bus.busy, 1);
    step();
    s_stop = n_stop;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("t3_abort_nostop", bus.dump_stop, 0);
    check("t3_abort_idle", bus.busy, 0);
    step();
    check("t3_stopcnt", n_stop - s_stop, 0);

    // 4: late arm
    do_reset();
    frames(10);
    check("t4_cnt10", bus.frame_cnt, 10);
    do_arm(1'b0, 5, 1, 0);
    check("t4_late", bus.late, 1);
    vfall();
    check("t4_start", bus.dump_start, 1);
    check("t4_cnt11", bus.frame_cnt, 11);
    vrise();
    vfall();
    check("t4_stop", bus.dump_stop, 1);
    vrise();

    // 5: abort with vs_fall and arm in the same cycle
    do_arm(1'b0, 0, 0, 0);
    vfall();
    check("t5_en", bus.dump_en, 1);
    vrise();
    step();
    s_start = n_start;
    s_stop  = n_stop;
    bus.vs = 1'b0; bus.arm = 1'b1; bus.abort = 1'b1;
    step();
    bus.arm = 1'b0; bus.abort = 1'b0;
    check("t5_stop", bus.dump_stop, 1);
    check("t5_nostart", bus.dump_start, 0);
    check("t5_en_off", bus.dump_en, 0);
    check("t5_idle", bus.busy, 0);
    check("t5_cnt", bus.frame_cnt, 14);
    bus.vs = 1'b1;
    step();
    step();
    check("t5_nstop", n_stop - s_stop, 1);
    check("t5_nstart", n_start - s_start, 0);

    // 6: unlimited window, cut by download
    do_reset();
    do_arm(1'b0, 0, 0, 0);
    vfall();
    check("t6_start", bus.dump_start, 1);
    vrise();
    step();
    s_stop = n_stop;
    frames(100);
    check("t6_en100", bus.dump_en, 1);
    check("t6_nostop", n_stop - s_stop, 0);
    bus.downloading = 1'b1;
    step();
    check("t6_stop", bus.dump_stop, 1);
    check("t6_en_off", bus.dump_en, 0);
    check("t6_busy", bus.busy, 1);
    check("t6_wdone", bus.win_done, 0);
    bus.downloading = 1'b0;
    step();
    check("t6_cnt0", bus.frame_cnt, 0);

    // async reset mid-window drops dump_en without a stop pulse
    do_reset();
    do_arm(1'b0, 0, 0, 0);
    vfall();
    check("t7_en", bus.dump_en, 1);
    vrise();
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_en_async", bus.dump_en, 0);
    check("t7_nostop", bus.dump_stop, 0);
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
